// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Time-shares one 11-bit ripple-carry adder between two requesters.
//   An accepted request produces its sum two cycles later. The sum is then
//   held until the consumer takes it, after which the block is free for the
//   next request.
//
//   Configuration macro: ADDER_ARB_RR_EN
//     defined   -> round-robin arbitration on contention
//     undefined -> fixed priority, requester 0 always wins (default build)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   req0_valid  requester 0 has an addition pending
//   req0_a/b    requester 0 operands (W bits)
//   req0_ready  requester 0 operands accepted this cycle
//   req1_*      same for requester 1
//   res_valid   result held on res_sum/res_id
//   res_ready   consumer accepts result this cycle
//   res_sum     unsigned sum, carry-out in MSB (W+1 bits)
//   res_id      requester that owns res_sum
// -----------------------------------------------------------------------------

// Shared 11-bit ripple-carry adder, carry-in tied to 0.
module adder_arbiter_rca11 (
   input  logic [10:0] a_i,
   input  logic [10:0] b_i,
   output logic [11:0] sum_o
);
   logic [11:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < 11; i++) begin : g_fa
      assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign sum_o[11] = carry[11];
endmodule

module adder_arbiter #(
   parameter int W = 11  // only 11 matches the shared adder
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W:0]   res_sum,
   output logic         res_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t       state_q;
   logic         res_valid_q;
   logic [W:0]   res_sum_q;
   logic         res_id_q;

   logic [W-1:0] op_a_q, op_a_d;
   logic [W-1:0] op_b_q, op_b_d;
   logic         op_id_q, op_id_d;

   logic         gnt0, gnt1, accept;
   logic [W:0]   adder_sum;

`ifdef ADDER_ARB_RR_EN
   // Requester favoured on the next contention.
   logic         ptr_q;
`endif

   // Grant is a same-cycle handshake: ready depends on valid while IDLE.
   // Holding it low during reset keeps reset cycles free of handshakes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && state_q == IDLE) begin
`ifdef ADDER_ARB_RR_EN
         if (req0_valid && req1_valid) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
`else
         gnt0 = req0_valid;
         gnt1 = req1_valid & ~req0_valid;
`endif
      end
   end

   assign accept     = gnt0 | gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Operand capture mux feeding the registers below.
   always_comb begin
      op_a_d  = gnt1 ? req1_a : req0_a;
      op_b_d  = gnt1 ? req1_b : req0_b;
      op_id_d = gnt1;
   end

   // NOTE: operand registers carry no reset; they are only consumed in ADD,
   // which is reachable solely through a grant that loads them first.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         op_id_q <= op_id_d;
      end
   end

   adder_arbiter_rca11 u_rca (
      .a_i   (op_a_q),
      .b_i   (op_b_q),
      .sum_o (adder_sum)
   );

   // Control FSM with registered result outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      if (rst) begin
         state_q     <= IDLE;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_id_q    <= 1'b0;
`ifdef ADDER_ARB_RR_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= ADD;
`ifdef ADDER_ARB_RR_EN
                  // Favour the requester that was not just served.
                  ptr_q   <= gnt0;
`endif
               end
            end
            ADD: begin
               res_sum_q   <= adder_sum;
               res_id_q    <= op_id_q;
               res_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Self-checking bench for adder_arbiter. A monitor on the falling edge keeps
//   a transaction-level model: which requester should win, whether a request
//   is in flight, and the expected sum of each accepted request (queued at
//   acceptance, popped when the consumer takes the result).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [10:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        res_valid, res_ready;
   logic [11:0] res_sum;
   logic        res_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int sum;
      bit id;
   } exp_t;

   exp_t exp_q[$];

   adder_arbiter #(.W(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_id     (res_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- monitor
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          busy = 1'b0;
   bit          ptr_m = 1'b0;
   bit          prev_valid = 1'b0;
   bit          prev_hs = 1'b0;
   logic [11:0] prev_sum;
   logic        prev_id;

   always @(negedge clk) begin : monitor
      bit   win;
      bit   exp0, exp1;
      exp_t e;
      cyc++;
      if (rst) begin
         check("rst_no_ready", {req0_ready, req1_ready}, 2'b00);
         exp_q.delete();
         busy       = 1'b0;
         ptr_m      = 1'b0;
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         check("one_ready", req0_ready & req1_ready, 0);
         if (busy) begin
            check("ready_while_busy", req0_ready | req1_ready, 0);
         end else begin
            exp0 = 1'b0;
            exp1 = 1'b0;
            win  = 1'b0;
            if (req0_valid || req1_valid) begin
`ifdef ADDER_ARB_RR_EN
               win = (req0_valid && req1_valid) ? ptr_m : req1_valid;
`else
               win = !req0_valid;
`endif
               exp0 = !win;
               exp1 = win;
            end
            check("grant0", req0_ready, exp0);
            check("grant1", req1_ready, exp1);
            if (req0_valid || req1_valid) begin
               e.sum = win ? int'(req1_a) + int'(req1_b) : int'(req0_a) + int'(req0_b);
               e.id  = win;
               exp_q.push_back(e);
               busy    = 1'b1;
               acc_cyc = cyc;
               ptr_m   = !win;
            end
         end

         check("no_spurious_valid", res_valid && exp_q.size() == 0, 0);
         if (busy && !res_valid)
            check("result_timeout", cyc > acc_cyc + 2, 0);
         if (res_valid && exp_q.size() > 0) begin
            if (!prev_valid) begin
               check("latency", cyc - acc_cyc, 2);
            end else if (!prev_hs) begin
               check("hold_sum", res_sum, prev_sum);
               check("hold_id", res_id, prev_id);
            end
            if (res_ready) begin
               e = exp_q.pop_front();
               check("res_sum", res_sum, e.sum);
               check("res_id", res_id, e.id);
               busy = 1'b0;
            end
         end
         prev_valid = res_valid;
         prev_hs    = res_valid & res_ready;
         prev_sum   = res_sum;
         prev_id    = res_id;
      end
   end

   // ----------------------------------------------------------------- driver
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string name);
      int n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, req0_ready | req1_ready, 1);
   endtask

   task automatic wait_res(input string name);
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, res_valid, 1);
   endtask

   initial begin
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a     = '0;
      req0_b     = '0;
      req1_a     = '0;
      req1_b     = '0;
      res_ready  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_res_valid", res_valid, 0);
      check("reset_res_sum", res_sum, 0);
      check("reset_res_id", res_id, 0);
      tick();
      rst = 1'b0;

      // Single request, carry into bit 11
      res_ready  = 1'b1;
      req0_valid = 1'b1;
      req0_a     = 11'h7FF;
      req0_b     = 11'h001;
      wait_accept("accept_single");
      tick();
      req0_valid = 1'b0;
      wait_res("res_single");

      // Maximum operands on requester 1
      tick();
      req1_valid = 1'b1;
      req1_a     = 11'h7FF;
      req1_b     = 11'h7FF;
      wait_accept("accept_max");
      tick();
      req1_valid = 1'b0;
      wait_res("res_max");

      // Contention: both valid continuously
      tick();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         req0_a = 11'($urandom);
         req0_b = 11'($urandom);
         req1_a = 11'($urandom);
         req1_b = 11'($urandom);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) tick();

      // Backpressure: result held for 5 cycles with both requesters waiting
      res_ready  = 1'b0;
      req0_valid = 1'b1;
      req0_a     = 11'h2AA;
      req0_b     = 11'h155;
      wait_accept("accept_bp");
      tick();
      req1_valid = 1'b1;
      req1_a     = 11'h0F0;
      req1_b     = 11'h00F;
      wait_res("res_bp");
      repeat (5) tick();
      res_ready  = 1'b1;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) tick();

      // Reset while holding a result
      res_ready  = 1'b0;
      req0_valid = 1'b1;
      req0_a     = 11'h100;
      req0_b     = 11'h200;
      wait_accept("accept_hold_rst");
      tick();
      req0_valid = 1'b0;
      wait_res("res_hold_rst");
      tick();
      rst        = 1'b1;
      req1_valid = 1'b1;
      req1_a     = 11'h321;
      req1_b     = 11'h123;
      tick();
      rst        = 1'b0;
      @(negedge clk);
      check("hold_rst_valid", res_valid, 0);
      check("hold_rst_sum", res_sum, 0);
      check("hold_rst_id", res_id, 0);
      check("hold_rst_req1_first", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      wait_res("res_after_rst");

      // Operand mutation after acceptance
      tick();
      req0_valid = 1'b1;
      req0_a     = 11'h123;
      req0_b     = 11'h456;
      wait_accept("accept_mut");
      tick();
      req0_valid = 1'b0;
      req0_a     = 11'h7FF;
      req0_b     = 11'h000;
      wait_res("res_mut");

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         tick();
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_a     = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom);
         req0_b     = 11'($urandom);
         req1_a     = 11'($urandom);
         req1_b     = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom);
         res_ready  = ($urandom_range(0, 3) != 0);
      end

      // Drain
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
